// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if: received sync pair plus the rebuilt position and lock status
interface vga_sync_decoder_if;
   logic       hSync;
   logic       vSync;
   logic [7:0] xCoord;
   logic [8:0] yCoord;
   logic       draw;
   logic       locked;
   logic       syncError;
   logic       frameStart;
   logic [9:0] hPeriod;
   logic [9:0] vPeriod;
   modport master (
      output hSync, vSync,
      input  xCoord, yCoord, draw, locked, syncError, frameStart, hPeriod, vPeriod
   );
   modport slave (
      input  hSync, vSync,
      output xCoord, yCoord, draw, locked, syncError, frameStart, hPeriod, vPeriod
   );
endinterface

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: rebuilds pixel position and lock status from a received VGA sync pair
module vga_sync_decoder #(
   parameter int H_TOTAL    = 800,
   parameter int V_TOTAL    = 521,
   parameter int HSYNC_POS  = 656,
   parameter int VSYNC_POS  = 490,
   parameter int ACT_W      = 256,
   parameter int ACT_H      = 320,
   parameter int LOCK_LINES = 4
) (
   input logic               clk25,
   input logic               reset,
   vga_sync_decoder_if.slave bus
);
   localparam int GW = $clog2(LOCK_LINES + 1);
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_NOM  = 10'(H_TOTAL);
   localparam logic [9:0] V_NOM  = 10'(V_TOTAL);
   localparam logic [9:0] H_LOAD = 10'(HSYNC_POS + 1);
   localparam logic [9:0] V_LOAD = 10'(VSYNC_POS);
   localparam logic [9:0] ACT_X  = 10'(ACT_W);
   localparam logic [9:0] ACT_Y  = 10'(ACT_H);
   localparam logic [9:0] SAT    = 10'h3ff;
   localparam logic [GW-1:0] LOCK_N = GW'(LOCK_LINES);

   typedef enum logic [1:0] {SEARCH, HTRACK, VTRACK, LOCKED} state_t;

   state_t        state, state_n;
   logic          hs_prev, vs_prev, h_fall, v_fall, h_wrap, timeout, h_bad, v_bad;
   logic [9:0]    h_pos, v_pos, h_per, line_cnt;
   logic [GW-1:0] good_lines, good_n;
   logic          v_seen, seen_n, locked_n, error_n;

   assign h_fall  = ~bus.hSync & hs_prev;
   assign v_fall  = ~bus.vSync & vs_prev;
   assign h_wrap  = ~h_fall & (h_pos == H_LAST);
   assign timeout = (h_per == SAT) & ~h_fall;
   assign h_bad   = h_fall & (h_per != H_NOM);
   assign v_bad   = v_fall & (line_cnt != V_NOM);

   // edge history, free-running position counters and period measurement
   always_ff @(posedge clk25) begin
      if (reset) begin
         hs_prev     <= 1'b1;
         vs_prev     <= 1'b1;
         h_pos       <= '0;
         v_pos       <= '0;
         h_per       <= '0;
         line_cnt    <= '0;
         bus.hPeriod <= '0;
         bus.vPeriod <= '0;
      end else begin
         hs_prev  <= bus.hSync;
         vs_prev  <= bus.vSync;
         h_pos    <= h_fall ? H_LOAD : h_wrap ? 10'd0 : h_pos + 10'd1;
         v_pos    <= v_fall ? V_LOAD : !h_wrap ? v_pos : (v_pos == V_LAST) ? 10'd0 : v_pos + 10'd1;
         h_per    <= h_fall ? 10'd1 : (h_per == SAT) ? h_per : h_per + 10'd1;
         line_cnt <= v_fall ? {9'd0, h_fall} : (h_fall && line_cnt != SAT) ? line_cnt + 10'd1 : line_cnt;
         if (h_fall) bus.hPeriod <= h_per;
         if (v_fall) bus.vPeriod <= line_cnt;
      end
   end

   // lock state, good-line count and registered status flags
   always_ff @(posedge clk25) begin
      if (reset) begin
         state         <= SEARCH;
         good_lines    <= '0;
         v_seen        <= 1'b0;
         bus.locked    <= 1'b0;
         bus.syncError <= 1'b0;
      end else begin
         state         <= state_n;
         good_lines    <= good_n;
         v_seen        <= seen_n;
         bus.locked    <= locked_n;
         bus.syncError <= error_n;
      end
   end

   // lock acquisition: line lengths first, then one full frame between two vSync edges
   always_comb begin
      state_n = state;
      good_n  = good_lines;
      seen_n  = v_seen;
      case (state)
         SEARCH: begin
            if (h_fall) begin
               state_n = HTRACK;
               good_n  = '0;
            end
         end
         HTRACK: begin
            if (timeout) begin
               state_n = SEARCH;
            end else if (h_fall) begin
               good_n = h_bad ? '0 : good_lines + GW'(1);
               if (!h_bad && good_n == LOCK_N) begin
                  state_n = VTRACK;
                  seen_n  = 1'b0;
               end
            end
         end
         VTRACK: begin
            if (timeout) begin
               state_n = SEARCH;
            end else if (h_bad) begin
               state_n = HTRACK;
               good_n  = '0;
            end else if (v_fall) begin
               seen_n  = 1'b1;
               state_n = (v_seen && !v_bad) ? LOCKED : VTRACK;
            end
         end
         default: state_n = (timeout || h_bad || v_bad) ? SEARCH : LOCKED;
      endcase
   end

   // status flags follow the next state; an error marks any exit from LOCKED
   always_comb begin
      locked_n = (state_n == LOCKED);
      error_n  = (state == LOCKED) && (state_n != LOCKED);
   end

   assign bus.draw       = bus.locked & (h_pos < ACT_X) & (v_pos < ACT_Y);
   assign bus.xCoord     = bus.draw ? h_pos[7:0] : 8'd0;
   assign bus.yCoord     = bus.draw ? v_pos[8:0] : 9'd0;
   assign bus.frameStart = bus.locked & (h_pos == 10'd0) & (v_pos == 10'd0);
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed checks of the sync decoder against a shrunken timing generator
module tb_vga_sync_decoder;
   localparam int HT = 40, VT = 12, HSP = 30, VSP = 9, AW = 16, AH = 6, LL = 4;

   typedef struct {
      logic       hs;
      logic       vs;
      logic [9:0] hp;
      logic [9:0] vp;
   } vec_t;

   logic clk = 1'b0, rst = 1'b1;
   logic raw = 1'b1, raw_hs = 1'b1, raw_vs = 1'b1;
   logic dly = 1'b0, frc = 1'b0, short_f = 1'b0;
   int   gh = 0, gv = 0, cyc = 0;
   int   checks = 0, failures = 0;
   vec_t vecs [13];

   always #5 clk = ~clk;

   vga_sync_decoder_if bus();

   vga_sync_decoder #(
      .H_TOTAL(HT), .V_TOTAL(VT), .HSYNC_POS(HSP), .VSYNC_POS(VSP),
      .ACT_W(AW), .ACT_H(AH), .LOCK_LINES(LL)
   ) dut (
      .clk25(clk),
      .reset(rst),
      .bus(bus)
   );

   // reference generator: counts pixels/lines, sync derived from the counts
   always @(posedge clk) begin
      cyc <= rst ? 0 : cyc + 1;
      if (rst) begin
         gh <= 0;
         gv <= 0;
      end else if (gh == HT - 1) begin
         gh <= 0;
         gv <= (gv == (short_f ? VT - 2 : VT - 1)) ? 0 : gv + 1;
      end else begin
         gh <= gh + 1;
      end
   end

   assign bus.hSync = raw ? raw_hs : (frc | ~(gh >= (dly ? HSP + 3 : HSP) && gh < HSP + 4));
   assign bus.vSync = raw ? raw_vs : (frc | ~(gv >= VSP && gv < VSP + 2));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic reset_dut(input int n);
      @(negedge clk);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_cmp(input int n, output int fs);
      logic        ed;
      logic [18:0] ex;
      fs = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ed = (gh < AW) && (gv < AH);
         ex = {ed ? gh[7:0] : 8'd0, ed ? gv[8:0] : 9'd0, ed, gh == 0 && gv == 0};
         chk("pos", {13'd0, bus.xCoord, bus.yCoord, bus.draw, bus.frameStart}, {13'd0, ex});
         fs += int'(bus.frameStart);
      end
   endtask

   task automatic wait_lock(input int bound, output logic ok, output int errs);
      ok   = 1'b0;
      errs = 0;
      for (int i = 0; i < bound && !ok; i++) begin
         @(negedge clk);
         errs += int'(bus.syncError);
         ok = bus.locked;
      end
   endtask

   task automatic check_reset_values(input string nm);
      chk({nm, "_lock"}, {31'd0, bus.locked}, 0);
      chk({nm, "_err"}, {31'd0, bus.syncError}, 0);
      chk({nm, "_draw"}, {31'd0, bus.draw}, 0);
      chk({nm, "_fs"}, {31'd0, bus.frameStart}, 0);
      chk({nm, "_xy"}, {15'd0, bus.xCoord, bus.yCoord}, 0);
      chk({nm, "_per"}, {12'd0, bus.hPeriod, bus.vPeriod}, 0);
   endtask

   initial begin
      logic ok;
      int   n, lf;
      vecs[0]  = '{1'b0, 1'b0, 10'd0, 10'd0};
      vecs[1]  = '{1'b1, 1'b1, 10'd0, 10'd0};
      vecs[2]  = '{1'b1, 1'b1, 10'd0, 10'd0};
      vecs[3]  = '{1'b0, 1'b1, 10'd3, 10'd0};
      vecs[4]  = '{1'b0, 1'b1, 10'd3, 10'd0};
      vecs[5]  = '{1'b1, 1'b1, 10'd3, 10'd0};
      vecs[6]  = '{1'b0, 1'b1, 10'd3, 10'd0};
      vecs[7]  = '{1'b1, 1'b0, 10'd3, 10'd3};
      vecs[8]  = '{1'b0, 1'b0, 10'd2, 10'd3};
      vecs[9]  = '{1'b1, 1'b1, 10'd2, 10'd3};
      vecs[10] = '{1'b1, 1'b0, 10'd2, 10'd1};
      vecs[11] = '{1'b0, 1'b1, 10'd3, 10'd1};
      vecs[12] = '{1'b1, 1'b0, 10'd3, 10'd1};

      repeat (10) @(negedge clk);
      check_reset_values("rst_hold");
      rst = 1'b0;
      for (int i = 0; i < 13; i++) begin
         raw_hs = vecs[i].hs;
         raw_vs = vecs[i].vs;
         @(negedge clk);
         chk($sformatf("vec%0d_hp", i), {22'd0, bus.hPeriod}, {22'd0, vecs[i].hp});
         chk($sformatf("vec%0d_vp", i), {22'd0, bus.vPeriod}, {22'd0, vecs[i].vp});
         chk($sformatf("vec%0d_lock", i), {31'd0, bus.locked}, 0);
      end

      reset_dut(3);
      raw = 1'b0;
      repeat (840) @(negedge clk);
      chk("lock_before_841", {31'd0, bus.locked}, 0);
      @(negedge clk);
      chk("lock_at_841", {31'd0, bus.locked}, 1);
      run_cmp(960, n);
      chk("frame_starts", n, 2);
      chk("h_period", {22'd0, bus.hPeriod}, HT);
      chk("v_period", {22'd0, bus.vPeriod}, VT);

      for (int i = 0; i < 100 && gh != 5; i++) @(negedge clk);
      dly = 1'b1;
      for (int i = 0; i < 100 && gh != 33; i++) @(negedge clk);
      chk("glitch_pre_lock", {31'd0, bus.locked}, 1);
      chk("glitch_pre_err", {31'd0, bus.syncError}, 0);
      @(negedge clk);
      chk("glitch_err", {31'd0, bus.syncError}, 1);
      chk("glitch_lock", {31'd0, bus.locked}, 0);
      chk("glitch_draw", {31'd0, bus.draw}, 0);
      @(negedge clk);
      chk("glitch_err_one", {31'd0, bus.syncError}, 0);
      dly = 1'b0;
      wait_lock(3000, ok, n);
      chk("glitch_relock", {31'd0, ok}, 1);
      chk("glitch_relock_err", n, 0);
      chk("glitch_relock_vp", {22'd0, bus.vPeriod}, VT);
      run_cmp(480, n);

      for (int i = 0; i < 100 && gh != 35; i++) @(negedge clk);
      frc = 1'b1;
      lf = cyc - 4;
      for (int i = 0; i < 1100 && !bus.syncError; i++) @(negedge clk);
      chk("timeout_err", {31'd0, bus.syncError}, 1);
      chk("timeout_dist", cyc - lf, 1023);
      chk("timeout_lock", {31'd0, bus.locked}, 0);
      @(negedge clk);
      chk("timeout_err_one", {31'd0, bus.syncError}, 0);
      frc = 1'b0;

      short_f = 1'b1;
      reset_dut(2);
      n = 0;
      repeat (1800) begin
         @(negedge clk);
         n += int'(bus.locked);
      end
      chk("short_nolock", n, 0);
      chk("short_vp", {22'd0, bus.vPeriod}, VT - 1);
      chk("short_hp", {22'd0, bus.hPeriod}, HT);
      for (int i = 0; i < 600 && gv != 2; i++) @(negedge clk);
      short_f = 1'b0;
      wait_lock(1500, ok, n);
      chk("full_frame_lock", {31'd0, ok}, 1);
      chk("full_frame_vp", {22'd0, bus.vPeriod}, VT);

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_values("mid_rst");
      rst = 1'b0;
      repeat (840) @(negedge clk);
      chk("relock_before_841", {31'd0, bus.locked}, 0);
      @(negedge clk);
      chk("relock_at_841", {31'd0, bus.locked}, 1);
      run_cmp(100, n);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator. It watches the active-low hSync/vSync pair on the clk25 domain and rebuilds the pixel position cycle-exactly from the sync edges. It checks line and frame lengths against nominal 640x480-class timing and reports lock. It produces the same xCoord/yCoord/draw window signals as the generator, so capture, overlay or self-check logic can run from a received sync stream.

## Interface
- H_TOTAL, 800: clocks per line.
- V_TOTAL, 521: lines per frame.
- HSYNC_POS, 656: pixel index of the first hSync-low cycle.
- VSYNC_POS, 490: line index of the first vSync-low line.
- ACT_W, 256: active window width.
- ACT_H, 320: active window height.
- LOCK_LINES, 4: consecutive good lines needed for horizontal lock.
- clk25  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high.
- hSync  in  1  horizontal sync, active low, clk25-synchronous.
- vSync  in  1  vertical sync, active low, clk25-synchronous.
- xCoord  out  8  hPos[7:0] when draw, else 0.
- yCoord  out  9  vPos[8:0] when draw, else 0.
- draw  out  1  locked & hPos<ACT_W & vPos<ACT_H.
- locked  out  1  registered; high in LOCKED only.
- syncError  out  1  registered one-cycle pulse on loss of lock.
- frameStart  out  1  locked & hPos==0 & vPos==0.
- hPeriod  out  10  last measured line length in clocks.
- vPeriod  out  10  last measured frame length in lines.

## Operation
- Edge detect: hsPrev/vsPrev registers hold the previous samples. hFall = ~hSync & hsPrev. vFall = ~vSync & vsPrev.
- hPos (10b): on hFall, load HSYNC_POS+1. Otherwise, if hPos==H_TOTAL-1, load 0; else increment. This makes hPos equal the generator's horizontal count on every cycle after the first hFall when the two are wired directly.
- vPos (10b): on vFall, load VSYNC_POS; the load overrides any wrap increment. Otherwise, when hPos wraps, go to 0 if vPos==V_TOTAL-1, else increment.
- hPer (10b, saturating at 1023): on hFall, latch hPeriod<=hPer and set hPer<=1. Otherwise increment. timeout = (hPer==1023) & ~hFall.
- lineCnt (10b, saturating): on vFall, latch vPeriod<=lineCnt and set lineCnt<=hFall (0 or 1; a coincident hFall counts toward the new frame). Otherwise increment on hFall.
- hGood = (hPer==H_TOTAL) at hFall. vGood = (lineCnt==V_TOTAL) at vFall.
- State machine, reset to SEARCH:
  - SEARCH: on hFall, go to HTRACK with goodLines=0.
  - HTRACK:
    - On timeout, go to SEARCH.
    - On hFall with hGood: goodLines++. When it reaches LOCK_LINES, go to VTRACK with vSeen=0.
    - On hFall without hGood: goodLines=0.
  - VTRACK:
    - On timeout, go to SEARCH.
    - On hFall without hGood, go to HTRACK with goodLines=0.
    - On vFall: if vSeen=0, set vSeen=1. Else, if vGood, go to LOCKED; otherwise stay.
  - LOCKED: go to SEARCH with a syncError pulse on any of: timeout, hFall without hGood, or vFall without vGood.
- When an hFall and a vFall fall in the same cycle, both checks are evaluated; any failure wins.
- Position counters free-run and keep reloading in every state. Only draw and frameStart are gated by locked.

## Timing
- Reset (synchronous): hPos=0, vPos=0, hsPrev=1, vsPrev=1, hPer=0, lineCnt=0, hPeriod=0, vPeriod=0, goodLines=0, vSeen=0, state=SEARCH, locked=0, syncError=0.
- Combinational outputs while reset is held: draw=0, xCoord=0, yCoord=0, frameStart=0.
- locked rises, or falls, on the same edge that changes the state. syncError is high for exactly the cycle after that edge.
- An input held low at reset release is detected as a falling edge on the first clock.
- Timeout: with no hFall after detection edge k, syncError (if LOCKED) asserts after edge k+1023.
- Lock time from a directly connected generator, with both reset together (edge 1 = first edge with reset low):
  - hFall edges are 657, 1457, and so on; VTRACK is entered at edge 3857.
  - vFall edges are 392001 and 808801; locked is high after edge 808801.

## Test plan
- Reset, with hSync=vSync=1 held for 10 cycles -> all outputs 0, state SEARCH.
- Generator connected -> locked=1 after edge 808801. After that, xCoord/yCoord/draw equal the generator's every cycle; hPeriod=800, vPeriod=521; frameStart high once per 416800 cycles.
- While LOCKED, delay one hSync falling edge by 3 cycles -> one-cycle syncError at that detection edge, locked=0, draw=0. Relock follows after 4 good lines plus two vSync edges, the second of which must be a full 521-line frame.
- While LOCKED, hold hSync high -> syncError 1023 cycles after the last hFall, locked=0.
- In VTRACK, present frames of 520 lines -> vPeriod=520 and locked stays 0. The first 521-line frame after that -> locked=1.
- Reset pulsed for 1 cycle mid-frame while LOCKED -> reset values next cycle; lock reacquired with the same latency as the lock-time test.
